// File: rtl/pc060ha_pkg.sv
// Shared constants for the PC060HA-style main/sound CPU mailbox.
package pc060ha_pkg;

    localparam int SLOTS = 4;
    localparam int DW    = 4;
    localparam int IDX_W = 3;
    localparam int NCTRL = 4;

    typedef logic [DW-1:0] nib_t;

    // Window index values written through the A0=0 register.
    localparam logic [IDX_W-1:0] IDX_SLOT0 = 3'd0;
    localparam logic [IDX_W-1:0] IDX_SLOT1 = 3'd1;
    localparam logic [IDX_W-1:0] IDX_SLOT2 = 3'd2;
    localparam logic [IDX_W-1:0] IDX_SLOT3 = 3'd3;
    localparam logic [IDX_W-1:0] IDX_STAT  = 3'd4;
    localparam logic [IDX_W-1:0] IDX_FULL  = 3'd5;
    localparam logic [IDX_W-1:0] IDX_OVR   = 3'd6;
    localparam logic [IDX_W-1:0] IDX_CTRL  = 3'd7;

    // Position of each control/status register inside the 4-entry control group.
    localparam int CSEL_STAT = int'(IDX_STAT - IDX_STAT);
    localparam int CSEL_FULL = int'(IDX_FULL - IDX_STAT);
    localparam int CSEL_OVR  = int'(IDX_OVR  - IDX_STAT);
    localparam int CSEL_CTRL = int'(IDX_CTRL - IDX_STAT);

    // Control bit positions.
    localparam int CTRL_SUB_RESET_BIT = 0;
    localparam int OVR_M2S_BIT        = 0;
    localparam int OVR_S2M_BIT        = 1;
    localparam int NMI_EN_BIT         = 0;
    localparam int NMI_PEND_BIT       = 1;
    localparam int NMI_ACK_BIT        = 1;

    // Indices 0..3 are data slots, 4..7 the control group.
    function automatic logic is_slot_idx(input logic [IDX_W-1:0] idx);
        return (idx < IDX_STAT);
    endfunction

endpackage

// File: rtl/pc060ha_cpu_port.sv
// One CPU side of the mailbox: index register, access decode, read mux and
// registered read data. Storage lives in the top; this block only steers it.
module pc060ha_cpu_port
    import pc060ha_pkg::*;
(
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       hold,
    input  logic                       cs,
    input  logic                       wr,
    input  logic                       a0,
    input  logic [IDX_W-1:0]           di_idx,
    input  logic [SLOTS-1:0][DW-1:0]   slot_rd_data,
    input  logic [NCTRL-1:0][DW-1:0]   ctrl_rd_data,
    output logic [SLOTS-1:0]           slot_wr,
    output logic [SLOTS-1:0]           slot_rd,
    output logic [NCTRL-1:0]           ctrl_wr,
    output logic [DW-1:0]              rdata
);

    logic [IDX_W-1:0] idx_q, idx_d;
    nib_t             rdata_q, rdata_d;
    logic [1:0]       sel;

    assign sel   = idx_q[1:0];
    assign rdata = rdata_q;

    // Decode one access; while held the side is frozen and its index parks at 0.
    always_comb begin
        idx_d   = idx_q;
        rdata_d = rdata_q;
        slot_wr = '0;
        slot_rd = '0;
        ctrl_wr = '0;
        if (hold) begin
            idx_d = '0;
        end else if (cs) begin
            if (!a0) begin
                if (wr) idx_d = di_idx;
                else    rdata_d = '0;
            end else if (is_slot_idx(idx_q)) begin
                if (wr) begin
                    slot_wr[sel] = 1'b1;
                end else begin
                    slot_rd[sel] = 1'b1;
                    rdata_d      = slot_rd_data[sel];
                end
            end else begin
                if (wr) ctrl_wr[sel] = 1'b1;
                else    rdata_d      = ctrl_rd_data[sel];
            end
        end
    end

    // Index and read-data registers.
    always_ff @(posedge clk) begin
        if (srst) begin
            idx_q   <= '0;
            rdata_q <= '0;
        end else begin
            idx_q   <= idx_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: rtl/pc060ha_mailbox_ctrl.sv
// Main/sound CPU mailbox: 4 nibble slots each way with full flags, sticky
// overrun bits, a sound-CPU reset line and an NMI raised by a slot-3 write.
module pc060ha_mailbox_ctrl #(
    parameter int SLOTS      = 4,
    parameter bit NMI_EN_RST = 1'b0
) (
    input  logic       MCLK,
    input  logic       RESET,
    input  logic       MAIN_CS,
    input  logic       MAIN_WR,
    input  logic       MAIN_A0,
    input  logic [3:0] MAIN_DI,
    output logic [3:0] MAIN_DO,
    input  logic       SUB_CS,
    input  logic       SUB_WR,
    input  logic       SUB_A0,
    input  logic [3:0] SUB_DI,
    output logic [3:0] SUB_DO,
    output logic       SUB_NMI,
    output logic       SUB_RESET
);
    import pc060ha_pkg::*;

    logic [SLOTS-1:0][DW-1:0] m2s_data, s2m_data;
    logic [SLOTS-1:0]         m2s_full, s2m_full;
    logic [SLOTS-1:0]         m2s_ovr_hit, s2m_ovr_hit;
    logic [SLOTS-1:0]         main_slot_wr, main_slot_rd, sub_slot_wr, sub_slot_rd;
    logic [NCTRL-1:0]         main_ctrl_wr, sub_ctrl_wr;
    logic [NCTRL-1:0][DW-1:0] main_ctrl_rd, sub_ctrl_rd;

    logic sub_reset_q, sub_reset_d;
    logic ovr_m2s_q, ovr_m2s_d, ovr_s2m_q, ovr_s2m_d;
    logic nmi_en_q, nmi_en_d, nmi_pend_q, nmi_pend_d;
    logic sub_nmi_q, sub_nmi_d;

    // Control-group read views for each side; unlisted entries read zero.
    always_comb begin
        main_ctrl_rd            = '0;
        main_ctrl_rd[CSEL_STAT] = s2m_full;
        main_ctrl_rd[CSEL_FULL] = m2s_full;
        main_ctrl_rd[CSEL_OVR]  = {2'b00, ovr_s2m_q, ovr_m2s_q};
        main_ctrl_rd[CSEL_CTRL] = {3'b000, sub_reset_q};
        sub_ctrl_rd             = '0;
        sub_ctrl_rd[CSEL_STAT]  = m2s_full;
        sub_ctrl_rd[CSEL_FULL]  = {2'b00, nmi_pend_q, nmi_en_q};
    end

    pc060ha_cpu_port u_main_port (
        .clk          (MCLK),
        .srst         (RESET),
        .hold         (1'b0),
        .cs           (MAIN_CS),
        .wr           (MAIN_WR),
        .a0           (MAIN_A0),
        .di_idx       (MAIN_DI[IDX_W-1:0]),
        .slot_rd_data (s2m_data),
        .ctrl_rd_data (main_ctrl_rd),
        .slot_wr      (main_slot_wr),
        .slot_rd      (main_slot_rd),
        .ctrl_wr      (main_ctrl_wr),
        .rdata        (MAIN_DO)
    );

    pc060ha_cpu_port u_sub_port (
        .clk          (MCLK),
        .srst         (RESET),
        .hold         (sub_reset_q),
        .cs           (SUB_CS),
        .wr           (SUB_WR),
        .a0           (SUB_A0),
        .di_idx       (SUB_DI[IDX_W-1:0]),
        .slot_rd_data (m2s_data),
        .ctrl_rd_data (sub_ctrl_rd),
        .slot_wr      (sub_slot_wr),
        .slot_rd      (sub_slot_rd),
        .ctrl_wr      (sub_ctrl_wr),
        .rdata        (SUB_DO)
    );

    // Control-group writes that have no effect on either side.
    logic unused_ctrl_wr;
    assign unused_ctrl_wr = ^{main_ctrl_wr[CSEL_FULL], main_ctrl_wr[CSEL_CTRL],
                              sub_ctrl_wr[CSEL_STAT], sub_ctrl_wr[CSEL_OVR],
                              sub_ctrl_wr[CSEL_CTRL]};

    genvar gi;
    generate
        for (gi = 0; gi < SLOTS; gi++) begin : g_slot
            nib_t m2s_data_q, m2s_data_d, s2m_data_q, s2m_data_d;
            logic m2s_full_q, m2s_full_d, s2m_full_q, s2m_full_d;

            // A write sets the flag and beats a same-cycle read clear; the
            // reader already sampled the old data through the read mux.
            always_comb begin
                m2s_data_d = m2s_data_q;
                m2s_full_d = m2s_full_q;
                s2m_data_d = s2m_data_q;
                s2m_full_d = s2m_full_q;
                if (main_slot_wr[gi]) begin
                    m2s_data_d = MAIN_DI;
                    m2s_full_d = 1'b1;
                end else if (sub_slot_rd[gi]) begin
                    m2s_full_d = 1'b0;
                end
                if (sub_slot_wr[gi]) begin
                    s2m_data_d = SUB_DI;
                    s2m_full_d = 1'b1;
                end else if (main_slot_rd[gi]) begin
                    s2m_full_d = 1'b0;
                end
                // s2m flags belong to the sound CPU and are cleared while it is in reset.
                if (sub_reset_d) s2m_full_d = 1'b0;
            end

            // Slot data and full-flag registers.
            always_ff @(posedge MCLK) begin
                if (RESET) begin
                    m2s_data_q <= '0;
                    m2s_full_q <= 1'b0;
                    s2m_data_q <= '0;
                    s2m_full_q <= 1'b0;
                end else begin
                    m2s_data_q <= m2s_data_d;
                    m2s_full_q <= m2s_full_d;
                    s2m_data_q <= s2m_data_d;
                    s2m_full_q <= s2m_full_d;
                end
            end

            assign m2s_data[gi]    = m2s_data_q;
            assign m2s_full[gi]    = m2s_full_q;
            assign s2m_data[gi]    = s2m_data_q;
            assign s2m_full[gi]    = s2m_full_q;
            assign m2s_ovr_hit[gi] = main_slot_wr[gi] & m2s_full_q;
            assign s2m_ovr_hit[gi] = sub_slot_wr[gi] & s2m_full_q;
        end
    endgenerate

    // Sound-CPU reset, overrun bits and NMI bookkeeping; sets win over clears.
    always_comb begin
        sub_reset_d = sub_reset_q;
        ovr_m2s_d   = ovr_m2s_q;
        ovr_s2m_d   = ovr_s2m_q;
        nmi_en_d    = nmi_en_q;
        nmi_pend_d  = nmi_pend_q;
        if (main_ctrl_wr[CSEL_STAT]) sub_reset_d = MAIN_DI[CTRL_SUB_RESET_BIT];
        if (main_ctrl_wr[CSEL_OVR]) begin
            if (MAIN_DI[OVR_M2S_BIT]) ovr_m2s_d = 1'b0;
            if (MAIN_DI[OVR_S2M_BIT]) ovr_s2m_d = 1'b0;
        end
        if (|m2s_ovr_hit) ovr_m2s_d = 1'b1;
        if (|s2m_ovr_hit) ovr_s2m_d = 1'b1;
        if (sub_ctrl_wr[CSEL_FULL]) begin
            nmi_en_d = SUB_DI[NMI_EN_BIT];
            if (SUB_DI[NMI_ACK_BIT]) nmi_pend_d = 1'b0;
        end
        if (main_slot_wr[SLOTS-1]) nmi_pend_d = 1'b1;
        if (sub_reset_d) begin
            nmi_en_d   = NMI_EN_RST;
            nmi_pend_d = 1'b0;
        end
        sub_nmi_d = nmi_pend_d & nmi_en_d;
    end

    // Control state registers; the sound CPU comes out of reset held.
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            sub_reset_q <= 1'b1;
            ovr_m2s_q   <= 1'b0;
            ovr_s2m_q   <= 1'b0;
            nmi_en_q    <= NMI_EN_RST;
            nmi_pend_q  <= 1'b0;
            sub_nmi_q   <= 1'b0;
        end else begin
            sub_reset_q <= sub_reset_d;
            ovr_m2s_q   <= ovr_m2s_d;
            ovr_s2m_q   <= ovr_s2m_d;
            nmi_en_q    <= nmi_en_d;
            nmi_pend_q  <= nmi_pend_d;
            sub_nmi_q   <= sub_nmi_d;
        end
    end

    assign SUB_RESET = sub_reset_q;
    assign SUB_NMI   = sub_nmi_q;

endmodule

// File: tb/tb_pc060ha_mailbox_ctrl.sv
// Directed bench for the mailbox: inputs change on the falling edge, outputs
// are checked on the following falling edge after the capturing rising edge.
module tb_pc060ha_mailbox_ctrl;

    logic       MCLK = 1'b0;
    logic       RESET = 1'b1;
    logic       MAIN_CS = 1'b0, MAIN_WR = 1'b0, MAIN_A0 = 1'b0;
    logic [3:0] MAIN_DI = 4'h0;
    logic [3:0] MAIN_DO;
    logic       SUB_CS = 1'b0, SUB_WR = 1'b0, SUB_A0 = 1'b0;
    logic [3:0] SUB_DI = 4'h0;
    logic [3:0] SUB_DO;
    logic       SUB_NMI, SUB_RESET;

    int n_cmp = 0;
    int n_err = 0;

    pc060ha_mailbox_ctrl #(.SLOTS(4), .NMI_EN_RST(1'b0)) dut (
        .MCLK      (MCLK),
        .RESET     (RESET),
        .MAIN_CS   (MAIN_CS),
        .MAIN_WR   (MAIN_WR),
        .MAIN_A0   (MAIN_A0),
        .MAIN_DI   (MAIN_DI),
        .MAIN_DO   (MAIN_DO),
        .SUB_CS    (SUB_CS),
        .SUB_WR    (SUB_WR),
        .SUB_A0    (SUB_A0),
        .SUB_DI    (SUB_DI),
        .SUB_DO    (SUB_DO),
        .SUB_NMI   (SUB_NMI),
        .SUB_RESET (SUB_RESET)
    );

    always #5 MCLK = ~MCLK;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-28s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic main_acc(input logic wr, input logic a0, input logic [3:0] d);
        @(negedge MCLK);
        MAIN_CS = 1'b1; MAIN_WR = wr; MAIN_A0 = a0; MAIN_DI = d;
        @(negedge MCLK);
        MAIN_CS = 1'b0; MAIN_WR = 1'b0;
    endtask

    task automatic sub_acc(input logic wr, input logic a0, input logic [3:0] d);
        @(negedge MCLK);
        SUB_CS = 1'b1; SUB_WR = wr; SUB_A0 = a0; SUB_DI = d;
        @(negedge MCLK);
        SUB_CS = 1'b0; SUB_WR = 1'b0;
    endtask

    // Select an index then read the window; result lands on MAIN_DO / SUB_DO.
    task automatic main_rd_idx(input logic [3:0] idx);
        main_acc(1'b1, 1'b0, idx);
        main_acc(1'b0, 1'b1, 4'h0);
    endtask

    task automatic sub_rd_idx(input logic [3:0] idx);
        sub_acc(1'b1, 1'b0, idx);
        sub_acc(1'b0, 1'b1, 4'h0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge MCLK);
        RESET = 1'b0;
        @(negedge MCLK);
        chk("rst MAIN_DO", MAIN_DO, 4'h0);
        chk("rst SUB_DO", SUB_DO, 4'h0);
        chk("rst SUB_RESET", {3'b0, SUB_RESET}, 4'h1);
        chk("rst SUB_NMI", {3'b0, SUB_NMI}, 4'h0);

        // Release sound CPU, send one nibble
        main_acc(1'b1, 1'b0, 4'h4);
        main_acc(1'b1, 1'b1, 4'h0);
        chk("release SUB_RESET", {3'b0, SUB_RESET}, 4'h0);
        main_acc(1'b1, 1'b0, 4'h0);
        main_acc(1'b1, 1'b1, 4'hA);
        main_rd_idx(4'h7);
        chk("main idx7 after release", MAIN_DO, 4'h0);
        main_rd_idx(4'h5);
        chk("main m2s_full slot0", MAIN_DO, 4'h1);
        sub_rd_idx(4'h4);
        chk("sub idx4 slot0 full", SUB_DO, 4'h1);
        sub_rd_idx(4'h0);
        chk("sub read slot0", SUB_DO, 4'hA);
        sub_rd_idx(4'h4);
        chk("sub idx4 after read", SUB_DO, 4'h0);

        // NMI on slot-3 write
        sub_acc(1'b1, 1'b0, 4'h5);
        sub_acc(1'b1, 1'b1, 4'h1);
        sub_acc(1'b0, 1'b1, 4'h0);
        chk("sub idx5 nmi_en", SUB_DO, 4'h1);
        for (int i = 0; i < 4; i++) begin
            main_acc(1'b1, 1'b0, 4'(i));
            main_acc(1'b1, 1'b1, 4'(i + 1));
            chk($sformatf("SUB_NMI after slot%0d wr", i), {3'b0, SUB_NMI}, (i == 3) ? 4'h1 : 4'h0);
        end
        sub_rd_idx(4'h4);
        chk("sub idx4 all full", SUB_DO, 4'hF);
        for (int i = 0; i < 4; i++) begin
            sub_rd_idx(4'(i));
            chk($sformatf("sub read slot%0d", i), SUB_DO, 4'(i + 1));
        end
        sub_rd_idx(4'h4);
        chk("sub idx4 all drained", SUB_DO, 4'h0);
        sub_rd_idx(4'h5);
        chk("sub idx5 pend+en", SUB_DO, 4'h3);
        sub_acc(1'b1, 1'b1, 4'h3);
        chk("SUB_NMI after ack", {3'b0, SUB_NMI}, 4'h0);
        sub_acc(1'b0, 1'b1, 4'h0);
        chk("sub idx5 after ack", SUB_DO, 4'h1);

        // Overrun on slot 2
        main_acc(1'b1, 1'b0, 4'h2);
        main_acc(1'b1, 1'b1, 4'h5);
        main_acc(1'b1, 1'b1, 4'h6);
        sub_rd_idx(4'h2);
        chk("sub read overwritten slot2", SUB_DO, 4'h6);
        main_rd_idx(4'h6);
        chk("main ovr_m2s set", MAIN_DO, 4'h1);
        main_acc(1'b1, 1'b1, 4'h1);
        main_acc(1'b0, 1'b1, 4'h0);
        chk("main ovr cleared", MAIN_DO, 4'h0);

        // Same-cycle sub write and main read of slot 1
        sub_acc(1'b1, 1'b0, 4'h1);
        sub_acc(1'b1, 1'b1, 4'h3);
        main_acc(1'b1, 1'b0, 4'h1);
        @(negedge MCLK);
        SUB_CS = 1'b1; SUB_WR = 1'b1; SUB_A0 = 1'b1; SUB_DI = 4'h7;
        MAIN_CS = 1'b1; MAIN_WR = 1'b0; MAIN_A0 = 1'b1;
        @(negedge MCLK);
        SUB_CS = 1'b0; SUB_WR = 1'b0; MAIN_CS = 1'b0;
        chk("collide main old data", MAIN_DO, 4'h3);
        main_rd_idx(4'h4);
        chk("collide s2m_full[1] set", MAIN_DO, 4'h2);
        main_rd_idx(4'h6);
        chk("collide ovr_s2m", MAIN_DO, 4'h2);
        main_acc(1'b1, 1'b1, 4'h2);
        main_rd_idx(4'h1);
        chk("main read new slot1", MAIN_DO, 4'h7);
        main_rd_idx(4'h4);
        chk("s2m_full drained", MAIN_DO, 4'h0);

        // Sound CPU put back into reset
        sub_acc(1'b1, 1'b0, 4'h0);
        sub_acc(1'b1, 1'b1, 4'h9);
        main_acc(1'b0, 1'b1, 4'h0);
        chk("s2m_full[0] before hold", MAIN_DO, 4'h1);
        main_acc(1'b1, 1'b1, 4'h1);
        chk("SUB_RESET reasserted", {3'b0, SUB_RESET}, 4'h1);
        main_acc(1'b0, 1'b1, 4'h0);
        chk("s2m_full cleared by hold", MAIN_DO, 4'h0);
        sub_acc(1'b1, 1'b0, 4'h1);
        sub_acc(1'b1, 1'b1, 4'h5);
        sub_acc(1'b0, 1'b1, 4'h0);
        chk("sub DO frozen in hold", SUB_DO, 4'h6);
        main_acc(1'b0, 1'b1, 4'h0);
        chk("held sub write ignored", MAIN_DO, 4'h0);
        main_acc(1'b1, 1'b0, 4'h0);
        main_acc(1'b1, 1'b1, 4'hC);
        main_acc(1'b1, 1'b0, 4'h3);
        main_acc(1'b1, 1'b1, 4'h4);
        chk("no NMI while held", {3'b0, SUB_NMI}, 4'h0);
        main_acc(1'b1, 1'b0, 4'h4);
        main_acc(1'b1, 1'b1, 4'h0);
        sub_rd_idx(4'h5);
        chk("sub idx5 after hold", SUB_DO, 4'h0);
        sub_rd_idx(4'h4);
        chk("m2s_full kept in hold", SUB_DO, 4'h9);
        sub_rd_idx(4'h0);
        chk("m2s slot0 kept", SUB_DO, 4'hC);
        sub_rd_idx(4'h3);
        chk("m2s slot3 kept", SUB_DO, 4'h4);
        sub_rd_idx(4'h2);
        chk("non-full slot2 read", SUB_DO, 4'h6);
        sub_rd_idx(4'h4);
        chk("non-full read no flag", SUB_DO, 4'h0);

        // Global reset in the middle of a message
        main_acc(1'b1, 1'b0, 4'h0);
        main_acc(1'b1, 1'b1, 4'h1);
        main_acc(1'b1, 1'b0, 4'h1);
        main_acc(1'b1, 1'b1, 4'h2);
        main_rd_idx(4'h5);
        chk("partial msg flags", MAIN_DO, 4'h3);
        @(negedge MCLK);
        RESET = 1'b1;
        @(negedge MCLK);
        RESET = 1'b0;
        chk("mid rst MAIN_DO", MAIN_DO, 4'h0);
        chk("mid rst SUB_DO", SUB_DO, 4'h0);
        chk("mid rst SUB_RESET", {3'b0, SUB_RESET}, 4'h1);
        main_acc(1'b0, 1'b1, 4'h0);
        chk("mid rst s2m slot0 data", MAIN_DO, 4'h0);
        main_rd_idx(4'h5);
        chk("mid rst m2s_full", MAIN_DO, 4'h0);
        main_rd_idx(4'h4);
        chk("mid rst s2m_full", MAIN_DO, 4'h0);
        main_rd_idx(4'h6);
        chk("mid rst ovr", MAIN_DO, 4'h0);
        main_rd_idx(4'h7);
        chk("mid rst idx7", MAIN_DO, 4'h1);
        main_acc(1'b1, 1'b0, 4'h2);
        main_acc(1'b1, 1'b1, 4'h3);
        main_rd_idx(4'h5);
        chk("only slot2 after rst", MAIN_DO, 4'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pc060ha_mailbox_ctrl.md
PC060HA_MAILBOX_CTRL -- requirements
Module: pc060ha_mailbox_ctrl

Interface
REQ-001 The block SHALL take parameter SLOTS, default 4, giving the number of 4-bit mailbox slots per direction (fixed at 4 in this revision).
REQ-002 The block SHALL take parameter NMI_EN_RST, default 0, giving the reset value of the sub-side NMI enable.
REQ-003 MCLK  in  1  is the single clock; all state SHALL update on the rising edge.
REQ-004 RESET  in  1  is the reset: synchronous, active-high.
REQ-005 MAIN_CS  in  1  is the main CPU access strobe, a one-MCLK pulse per access.
REQ-006 MAIN_WR  in  1  selects write (1) or read (0).
REQ-007 MAIN_A0  in  1  selects the index register (0) or the data/status window (1).
REQ-008 MAIN_DI  in  4  is the main write data; MAIN_DO  out  4  is the main read data.
REQ-009 SUB_CS, SUB_WR, SUB_A0, SUB_DI and SUB_DO SHALL mirror the main ports for the sound CPU.
REQ-010 SUB_NMI  out  1  is the NMI request to the sound CPU, active-high level.
REQ-011 SUB_RESET  out  1  is the sound CPU reset, active-high level.

Function
REQ-012 An access SHALL occur only in cycles with xx_CS=1; other cycles SHALL leave the state unchanged.
REQ-013 A write with A0=0 SHALL load DI[2:0] into that side's 3-bit index register.
REQ-014 A window access at index 0..3 SHALL address slot[index]; index 4..7 SHALL address control/status.
REQ-015 A main write at slot i SHALL store MAIN_DI in m2s[i] and set m2s_full[i].
REQ-016 A sub read at slot i SHALL return m2s[i] and clear m2s_full[i].
REQ-017 The s2m direction SHALL behave the same way: sub write sets s2m_full[i], main read clears it.
REQ-018 A read of a non-written slot SHALL return the stored value and SHALL NOT change any flag.
REQ-019 Read data SHALL be registered: DO becomes valid on the MCLK edge after CS and holds until the next read on that side.
REQ-020 A write to a slot whose full flag is already set SHALL overwrite the data, keep the flag set, and set the sticky overrun bit for that direction.
REQ-021 A main read at index 4 SHALL return s2m_full[3:0].
REQ-022 A main read at index 5 SHALL return m2s_full[3:0].
REQ-023 A main read at index 6 SHALL return {2'b0, ovr_s2m, ovr_m2s}.
REQ-024 A main read at index 7 SHALL return {3'b0, SUB_RESET}.
REQ-025 A main write at index 4 SHALL set SUB_RESET to DI[0]; a main write at index 6 SHALL clear each overrun bit whose DI bit is 1.
REQ-026 A sub read at index 4 SHALL return m2s_full[3:0].
REQ-027 A sub read at index 5 SHALL return {2'b0, nmi_pend, nmi_en}.
REQ-028 A sub write at index 5 SHALL set nmi_en to DI[0]; DI[1]=1 in the same write SHALL clear nmi_pend.
REQ-029 Any other index/direction combination SHALL read 4'h0 and its writes SHALL be ignored.
REQ-030 A main write to slot 3 SHALL set nmi_pend; SUB_NMI SHALL equal nmi_pend & nmi_en, registered, one cycle after the write.
REQ-031 Simultaneous set and clear of the same full flag in one cycle: set SHALL win; the reader gets the old data; the writer's data is stored.
REQ-032 Simultaneous nmi_pend set (main, slot 3) and clear (sub ack): set SHALL win.
REQ-033 While SUB_RESET=1, sub-side accesses SHALL be ignored and the sub index, nmi_en, nmi_pend and s2m_full SHALL be held at their reset values.
REQ-034 While SUB_RESET=1, m2s data and m2s_full SHALL be preserved.

Reset
REQ-035 On RESET=1 at an MCLK edge, the block SHALL clear all index registers, all full flags, all overrun bits, nmi_pend, MAIN_DO and SUB_DO, and SHALL set nmi_en=NMI_EN_RST, SUB_RESET=1 and SUB_NMI=0.
REQ-036 Slot data SHALL reset to 4'h0.
REQ-037 RESET asserted mid-sequence SHALL abort any partially filled message; no flag SHALL survive it.

Structure
REQ-038 Package pc060ha_pkg SHALL hold SLOTS, the index constants (IDX_SLOT0..3, IDX_STAT, IDX_FULL, IDX_OVR, IDX_CTRL) and the control bit positions.
REQ-039 One sub-module, pc060ha_cpu_port, SHALL implement a single CPU side (index register, decode, read mux, DO register) and SHALL be instantiated twice.

Verification
REQ-040 After reset, main writes A0=0 DI=4 then A0=1 DI=0; then main writes A0=0 DI=0 and A0=1 DI=A -> slot 0 is 4'hA, SUB_RESET=0, and a sub read at index 4 returns 4'h1.
REQ-041 With nmi_en=1, main writes slots 0..3 = 1,2,3,4 -> SUB_NMI=1 one cycle after the slot-3 write; sub reads return 1,2,3,4; m2s_full=0; a sub write at index 5 DI=3 drops SUB_NMI.
REQ-042 Main writes slot 2 twice (5 then 6) -> sub reads 6 and main index 6 reads 4'h1; a main write at index 6 DI=1 then reads 4'h0.
REQ-043 Sub write to slot 1 in the same cycle as a main read of slot 1 -> main gets the old data and s2m_full[1] stays 1.
REQ-044 Sub writes slot 0 and nmi_en=1, then main writes index 4 DI=1 -> s2m_full=0, nmi_en=0, sub accesses ignored, m2s contents intact.
REQ-045 RESET pulsed for one cycle between the slot-1 and slot-2 writes -> all flags read 0 and SUB_RESET=1.
